// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude adder arbiter.
//   - operand / result widths of the sign-magnitude formats
//   - FSM state encoding and the enum built on it
//   - sign-bit positions and the result normalisation helper
package sm_pkg;

    localparam int SM_IN_W  = 8;
    localparam int SM_OUT_W = 9;

    // Sign bit sits in the MSB of both formats.
    localparam int SM_IN_SIGN  = SM_IN_W - 1;
    localparam int SM_OUT_SIGN = SM_OUT_W - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_ADD  = S_ADD,
        ST_RESP = S_RESP
    } sm_state_t;

    // A zero magnitude is always reported as +0, whatever sign the adder chose.
    function automatic logic [SM_OUT_W-1:0] sm_normalise(input logic [SM_OUT_W-1:0] s);
        if (s[SM_OUT_SIGN-1:0] == '0)
            return '0;
        return s;
    endfunction

endpackage

// File: rtl/sm_add_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
// Ports:
//   req_valid  in   NREQ  request vector
//   rr_ptr     in   IDW   highest-priority index for this search
//   grant      out  NREQ  one-hot winner (all zero when nobody requests)
//   winner     out  IDW   index of the winner
//   any        out  1     at least one request present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    first;
    logic [IDW:0]      sum;

    always_comb begin
        // Rotate so that rr_ptr lands on bit 0; the doubled vector gives wrap-around.
        dbl = {req_valid, req_valid} >> rr_ptr;
        rot = dbl[NREQ-1:0];

        // Lowest set bit of the rotated vector is the winner's offset from rr_ptr.
        first = '0;
        any   = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                first = IDW'(j);
                any   = 1'b1;
            end
        end

        // Rotate back: (rr_ptr + offset) mod NREQ.
        sum = {1'b0, rr_ptr} + {1'b0, first};
        if (sum >= (IDW+1)'(NREQ))
            sum = sum - (IDW+1)'(NREQ);
        winner = sum[IDW-1:0];

        grant = '0;
        if (any)
            grant[winner] = 1'b1;
    end

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter / sequencer sharing one external combinational
// sign-magnitude adder between NREQ requesters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_a/req_b    per-requester operand pairs (8-bit sign-magnitude)
//   req_ready                one-hot accept, combinational in IDLE
//   add_a/add_b, add_sum     registered operands to / result from the shared adder
//   resp_valid/resp_id/resp_sum/resp_ready   tagged result handshake
//   busy                     high whenever an operation is in flight
module sm_add_arbiter
    import sm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [SM_IN_W*NREQ-1:0]  req_a,
    input  logic [SM_IN_W*NREQ-1:0]  req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [SM_IN_W-1:0]       add_a,
    output logic [SM_IN_W-1:0]       add_b,
    input  logic [SM_OUT_W-1:0]      add_sum,
    output logic                     resp_valid,
    output logic [IDW-1:0]           resp_id,
    output logic [SM_OUT_W-1:0]      resp_sum,
    input  logic                     resp_ready,
    output logic                     busy
);

    sm_state_t          state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     gnt_id;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     winner;
    logic               any;
    logic [SM_IN_W-1:0] sel_a;
    logic [SM_IN_W-1:0] sel_b;
    logic [IDW-1:0]     next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .winner    (winner),
        .any       (any)
    );

    // One-hot operand mux driven by the grant vector.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | req_a[i*SM_IN_W +: SM_IN_W];
                sel_b = sel_b | req_b[i*SM_IN_W +: SM_IN_W];
            end
        end
    end

    assign next_ptr = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

    // Accept only in IDLE; held off during reset so no transfer can be lost.
    assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            gnt_id     <= '0;
            add_a      <= '0;
            add_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        add_a  <= sel_a;
                        add_b  <= sel_b;
                        gnt_id <= winner;
                        rr_ptr <= next_ptr;
                        state  <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    resp_sum   <= sm_normalise(add_sum);
                    resp_id    <= gnt_id;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
